rf_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the register file's single write port between NUM_REQ producers (e.g. ALU, load unit, multiplier).
- Each producer presents a write over a valid/ready handshake. The block grants one producer per cycle.
- The granted write is registered and driven to the per-register write-enable FlipFlop array as rf_write/rf_addr/rf_data one cycle later.
- Register 0 is hardwired zero. Writes to it are accepted but never issued.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rr_pick.sv | 35 +++
 rtl/rf_write_arbiter.sv | 89 ++++++++
 tb/tb_rf_write_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the register-file write path.
// The requester enum names the producers that own each arbiter port.
package rf_pkg;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ZERO_REG = 0;

  typedef enum int unsigned {
    REQ_ALU  = 0,
    REQ_LOAD = 1,
    REQ_MUL  = 2
  } req_id_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward, wrapping.
// Shared by the write-port and read-port arbiters.
module rr_pick #(
  parameter  int N     = 3,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return PTR_W'(s);
  endfunction

  // Scan from the far end so the closest hit to ptr is the last one assigned.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[wrap_idx(ptr_i, k)]) begin
        idx_o = wrap_idx(ptr_i, k);
        any_o = 1'b1;
      end
    end
  end

  assign gnt_o = any_o ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port.
// The granted write is registered and issued one cycle after acceptance.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  parameter  int ADDR_W  = RF_ADDR_W,
  parameter  int DATA_W  = RF_DATA_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_write,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_data,
  output logic [IDX_W-1:0]          grant_idx,
  output logic [15:0]               write_count
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               rf_write_q, rf_write_d;
  logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]  rf_data_q, rf_data_d;
  logic [15:0]        write_count_q, write_count_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               accept;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign accept    = pick_any & ~hold;
  assign req_ready = {NUM_REQ{accept & reset}} & gnt;

  always_comb begin
    ptr_d         = ptr_q;
    grant_idx_d   = grant_idx_q;
    rf_write_d    = 1'b0;
    rf_addr_d     = rf_addr_q;
    rf_data_d     = rf_data_q;
    if (accept) begin
      ptr_d       = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
      grant_idx_d = pick_idx;
      rf_addr_d   = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
      rf_data_d   = req_data[int'(pick_idx)*DATA_W +: DATA_W];
      // Register 0 is hardwired: the write is consumed but never strobed.
      rf_write_d  = (rf_addr_d != ADDR_W'(RF_ZERO_REG));
    end
    write_count_d = write_count_q + 16'(rf_write_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q         <= '0;
      grant_idx_q   <= '0;
      rf_write_q    <= 1'b0;
      rf_addr_q     <= '0;
      rf_data_q     <= '0;
      write_count_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      grant_idx_q   <= grant_idx_d;
      rf_write_q    <= rf_write_d;
      rf_addr_q     <= rf_addr_d;
      rf_data_q     <= rf_data_d;
      write_count_q <= write_count_d;
    end
  end

  assign rf_write    = rf_write_q;
  assign rf_addr     = rf_addr_q;
  assign rf_data     = rf_data_q;
  assign grant_idx   = grant_idx_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a behavioural round-robin model,
// a per-cycle compare process and a small register-file image fed by the DUT.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  valid = 3'b000;
  logic [4:0]  a [3] = '{default: '0};
  logic [31:0] d [3] = '{default: '0};
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [1:0]  grant_idx;
  logic [15:0] write_count;

  int n_checks = 0;
  int n_errors = 0;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  rf_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .req_valid   (valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rf_write    (rf_write),
    .rf_addr     (rf_addr),
    .rf_data     (rf_data),
    .grant_idx   (grant_idx),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pointer, last issued write, issued-write count.
  int          m_ptr  = 0;
  bit          m_wr   = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_gidx = 0;
  int          m_cnt  = 0;

  function automatic int m_pick();
    if (hold) return -1;
    for (int k = 0; k < N; k++) begin
      if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    int g;
    if (!reset) begin
      m_ptr = 0; m_wr = 0; m_addr = '0; m_data = '0; m_gidx = 0; m_cnt = 0;
    end else begin
      g = m_pick();
      if (g >= 0) begin
        m_ptr  = (g + 1) % N;
        m_gidx = g;
        m_addr = a[g];
        m_data = d[g];
        m_wr   = (a[g] != 5'(RF_ZERO_REG));
        if (m_wr) m_cnt = (m_cnt + 1) % 65536;
      end else begin
        m_wr = 0;
      end
    end
  end

  logic [31:0] rf_mem [32] = '{default: '0};
  logic [2:0]  p_pend = 3'b000;
  logic [4:0]  p_a [3] = '{default: '0};
  logic [31:0] p_d [3] = '{default: '0};

  always @(negedge clk) begin : compare
    int g;
    logic [2:0] exp_rdy;
    g = m_pick();
    exp_rdy = (g >= 0 && reset) ? 3'(1 << g) : 3'b000;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rf_write", 64'(rf_write), 64'(m_wr));
    chk("rf_addr", 64'(rf_addr), 64'(m_addr));
    chk("rf_data", 64'(rf_data), 64'(m_data));
    chk("grant_idx", 64'(grant_idx), 64'(m_gidx));
    chk("write_count", 64'(write_count), 64'(m_cnt));
    // Requester contract: a waiting request keeps its payload stable.
    for (int i = 0; i < N; i++) begin
      if (reset && p_pend[i] && valid[i]) begin
        chk($sformatf("stable_addr%0d", i), 64'(a[i]), 64'(p_a[i]));
        chk($sformatf("stable_data%0d", i), 64'(d[i]), 64'(p_d[i]));
      end
    end
    if (rf_write) rf_mem[rf_addr] = rf_data;
    p_pend = reset ? (valid & ~req_ready) : 3'b000;
    for (int i = 0; i < N; i++) begin
      p_a[i] = a[i];
      p_d[i] = d[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic [4:0] ad, input logic [31:0] dt);
    a[i] = ad;
    d[i] = dt;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [2:0] seq [6];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_write", 64'(rf_write), 64'd0);
    chk("rst_rf_addr", 64'(rf_addr), 64'd0);
    chk("rst_rf_data", 64'(rf_data), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_write_count", 64'(write_count), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    step();

    // Single ALU write
    set_port(REQ_ALU, 5'd3, 32'hDEADBEEF);
    valid = 3'b001;
    #0 chk("alu_ready", 64'(req_ready), 64'b001);
    step();
    valid = 3'b000;
    chk("alu_rf_write", 64'(rf_write), 64'd1);
    chk("alu_rf_addr", 64'(rf_addr), 64'd3);
    chk("alu_rf_data", 64'(rf_data), 64'hDEADBEEF);
    chk("alu_count", 64'(write_count), 64'd1);

    // All three continuously valid from ptr=0
    pulse_reset();
    set_port(REQ_ALU, 5'd1, 32'hA0);
    set_port(REQ_LOAD, 5'd2, 32'hA1);
    set_port(REQ_MUL, 5'd3, 32'hA2);
    valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #0 chk($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(seq[k]));
      step();
      chk($sformatf("rr_write%0d", k), 64'(rf_write), 64'd1);
    end
    chk("rr_count", 64'(write_count), 64'd6);
    valid = 3'b000;
    step();

    // Write to register 0: accepted, not issued
    set_port(REQ_LOAD, 5'd0, 32'h55);
    valid = 3'b010;
    #0 chk("r0_ready", 64'(req_ready), 64'b010);
    step();
    chk("r0_rf_write", 64'(rf_write), 64'd0);
    chk("r0_count", 64'(write_count), 64'd6);
    chk("r0_grant_idx", 64'(grant_idx), 64'd1);

    // Hold with everything valid; release grants at the held pointer (2)
    set_port(REQ_LOAD, 5'd2, 32'hA1);
    valid = 3'b111;
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #0 chk("hold_ready", 64'(req_ready), 64'd0);
      step();
      chk("hold_rf_write", 64'(rf_write), 64'd0);
    end
    hold = 1'b0;
    #0 chk("release_ready", 64'(req_ready), 64'b100);
    step();
    hold = 1'b1;
    #0 chk("hold_keeps_write", 64'(rf_write), 64'd1);
    chk("hold_keeps_addr", 64'(rf_addr), 64'd3);
    chk("hold_ready2", 64'(req_ready), 64'd0);
    step();
    hold = 1'b0;

    // Same address from ports 0 and 2 with ptr=2
    valid = 3'b010;
    #0 chk("ptr2_setup_ready", 64'(req_ready), 64'b010);
    step();
    set_port(REQ_ALU, 5'd7, 32'h11);
    set_port(REQ_MUL, 5'd7, 32'h22);
    valid = 3'b101;
    #0 chk("same_ready_first", 64'(req_ready), 64'b100);
    step();
    valid = 3'b001;
    #0 chk("same_first_data", 64'(rf_data), 64'h22);
    chk("same_ready_second", 64'(req_ready), 64'b001);
    step();
    valid = 3'b000;
    chk("same_second_data", 64'(rf_data), 64'h11);
    step();
    chk("same_rf_final", 64'(rf_mem[7]), 64'h11);
    chk("same_count", 64'(write_count), 64'd10);

    // Reset the cycle after an accept
    set_port(REQ_ALU, 5'd9, 32'hABCD);
    valid = 3'b001;
    #0 chk("mid_ready", 64'(req_ready), 64'b001);
    step();
    valid = 3'b000;
    chk("mid_write_before", 64'(rf_write), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_write_dropped", 64'(rf_write), 64'd0);
    chk("mid_count_cleared", 64'(write_count), 64'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    set_port(REQ_ALU, 5'd1, 32'hB0);
    set_port(REQ_LOAD, 5'd2, 32'hB1);
    set_port(REQ_MUL, 5'd3, 32'hB2);
    valid = 3'b111;
    #1 chk("after_rst_ready", 64'(req_ready), 64'b001);
    step();
    valid = 3'b000;
    chk("after_rst_gidx", 64'(grant_idx), 64'd0);
    chk("after_rst_data", 64'(rf_data), 64'hB0);
    chk("after_rst_count", 64'(write_count), 64'd1);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
